// File: rtl/memory_march_sequencer_if.sv
// rtl/memory_march_sequencer_if.sv - memory macro port driven by the march sequencer
interface memory_march_sequencer_if #(
  parameter int ADDR_BITS = 4,
  parameter int DATA_BITS = 4
);
  logic                 mem_we;
  logic [ADDR_BITS-1:0] mem_addr;
  logic [DATA_BITS-1:0] mem_wdata;
  logic [DATA_BITS-1:0] mem_rdata;

  modport master (output mem_we, output mem_addr, output mem_wdata, input mem_rdata);
  modport slave  (input mem_we, input mem_addr, input mem_wdata, output mem_rdata);
endinterface

// File: rtl/memory_march_sequencer.sv
// rtl/memory_march_sequencer.sv - four-phase march self-test over the memory port
module memory_march_sequencer #(
  parameter int ADDR_BITS    = 4,
  parameter int DATA_BITS    = 4,
  parameter int READ_LATENCY = 1,
  parameter int ERR_BITS     = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [DATA_BITS-1:0] seed,
  memory_march_sequencer_if.master mem,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ERR_BITS-1:0]  err_count,
  output logic                 first_err_valid,
  output logic [ADDR_BITS-1:0] first_err_addr
);
  typedef enum logic [2:0] {
    S_IDLE, S_W_UP, S_R_UP, S_W_DN, S_R_DN, S_DRAIN, S_DONE
  } state_t;

  localparam int EW = (ADDR_BITS > DATA_BITS) ? ADDR_BITS : DATA_BITS;
  localparam logic [ADDR_BITS-1:0] ADDR_MAX   = '1;
  localparam logic [ERR_BITS-1:0]  ERR_MAX    = '1;
  localparam logic [2:0]           DRAIN_LAST = 3'(READ_LATENCY - 1);

  state_t               state;
  logic [ADDR_BITS-1:0] addr_q;
  logic [DATA_BITS-1:0] seed_q;
  logic [2:0]           drain_cnt;

  function automatic logic [DATA_BITS-1:0] pat(input logic [DATA_BITS-1:0] s,
                                               input logic [ADDR_BITS-1:0] a);
    logic [EW-1:0] ext;
    ext = EW'(a);
    return s ^ ext[DATA_BITS-1:0];
  endfunction

  logic                 reading;
  logic [DATA_BITS-1:0] rd_exp;
  assign reading = (state == S_R_UP) || (state == S_R_DN);
  assign rd_exp  = (state == S_R_DN) ? ~pat(seed_q, addr_q) : pat(seed_q, addr_q);

  // Port is decoded from registered state/address only, so it is quiet in IDLE/DONE/DRAIN.
  always_comb begin
    mem.mem_we    = 1'b0;
    mem.mem_addr  = '0;
    mem.mem_wdata = '0;
    case (state)
      S_W_UP: begin
        mem.mem_we    = 1'b1;
        mem.mem_addr  = addr_q;
        mem.mem_wdata = pat(seed_q, addr_q);
      end
      S_R_UP: mem.mem_addr = addr_q;
      S_W_DN: begin
        mem.mem_we    = 1'b1;
        mem.mem_addr  = addr_q;
        mem.mem_wdata = ~pat(seed_q, addr_q);
      end
      S_R_DN: mem.mem_addr = addr_q;
      default: ;
    endcase
  end

  logic abort_acc;
  logic start_acc;
  assign abort_acc = abort && busy;
  assign start_acc = start && !abort && ((state == S_IDLE) || (state == S_DONE));

  logic                 cmp_v;
  logic [ADDR_BITS-1:0] cmp_a;
  logic [DATA_BITS-1:0] cmp_e;

  generate
    if (READ_LATENCY == 0) begin : g_no_lat
      assign cmp_v = reading;
      assign cmp_a = addr_q;
      assign cmp_e = rd_exp;
    end else begin : g_lat
      logic [READ_LATENCY-1:0] pv;
      logic [ADDR_BITS-1:0]    pa [READ_LATENCY];
      logic [DATA_BITS-1:0]    pe [READ_LATENCY];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          pv <= '0;
          for (int i = 0; i < READ_LATENCY; i++) begin
            pa[i] <= '0;
            pe[i] <= '0;
          end
        end else if (abort_acc) begin
          pv <= '0;
        end else begin
          for (int i = READ_LATENCY - 1; i > 0; i--) begin
            pv[i] <= pv[i-1];
            pa[i] <= pa[i-1];
            pe[i] <= pe[i-1];
          end
          pv[0] <= reading;
          pa[0] <= addr_q;
          pe[0] <= rd_exp;
        end
      end

      assign cmp_v = pv[READ_LATENCY-1];
      assign cmp_a = pa[READ_LATENCY-1];
      assign cmp_e = pe[READ_LATENCY-1];
    end
  endgenerate

  logic                mismatch;
  logic [ERR_BITS-1:0] err_next;
  assign mismatch = cmp_v && (mem.mem_rdata != cmp_e);
  assign err_next = (mismatch && (err_count != ERR_MAX)) ? err_count + 1'b1 : err_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      addr_q          <= '0;
      seed_q          <= '0;
      drain_cnt       <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      err_count       <= '0;
      first_err_valid <= 1'b0;
      first_err_addr  <= '0;
    end else if (abort_acc) begin
      state  <= S_IDLE;
      addr_q <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      pass   <= 1'b0;
    end else if (start_acc) begin
      state           <= S_W_UP;
      addr_q          <= '0;
      seed_q          <= seed;
      drain_cnt       <= '0;
      busy            <= 1'b1;
      done            <= 1'b0;
      pass            <= 1'b0;
      err_count       <= '0;
      first_err_valid <= 1'b0;
      first_err_addr  <= '0;
    end else begin
      err_count <= err_next;
      if (mismatch && !first_err_valid) begin
        first_err_valid <= 1'b1;
        first_err_addr  <= cmp_a;
      end
      case (state)
        S_W_UP: begin
          addr_q <= addr_q + 1'b1;
          if (addr_q == ADDR_MAX) state <= S_R_UP;
        end
        S_R_UP: begin
          if (addr_q == ADDR_MAX) state <= S_W_DN;
          else addr_q <= addr_q + 1'b1;
        end
        S_W_DN: begin
          if (addr_q == '0) begin
            state  <= S_R_DN;
            addr_q <= ADDR_MAX;
          end else begin
            addr_q <= addr_q - 1'b1;
          end
        end
        S_R_DN: begin
          if (addr_q == '0) begin
            drain_cnt <= '0;
            if (READ_LATENCY == 0) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (err_next == '0);
            end else begin
              state <= S_DRAIN;
            end
          end else begin
            addr_q <= addr_q - 1'b1;
          end
        end
        S_DRAIN: begin
          // The final pipelined compare lands on this edge, so pass uses err_next.
          if (drain_cnt == DRAIN_LAST) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_next == '0);
          end else begin
            drain_cnt <= drain_cnt + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_memory_march_sequencer.sv
// tb/tb_memory_march_sequencer.sv - directed and randomized march runs against a reference model
module tb_memory_march_sequencer;
  logic       clk;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic [3:0] seed;

  logic       busy, done, pass, fev;
  logic [7:0] err_count;
  logic [3:0] fea;
  logic       busy3, done3, pass3, fev3;
  logic [2:0] err3;
  logic [3:0] fea3;

  int checks = 0;
  int failures = 0;

  logic [3:0] fault_addr = 4'h0;
  logic [3:0] fault_or   = 4'h0;
  logic [3:0] fault_and  = 4'h0;
  logic [3:0] mem [16];

  memory_march_sequencer_if #(.ADDR_BITS(4), .DATA_BITS(4)) m1 ();
  memory_march_sequencer_if #(.ADDR_BITS(4), .DATA_BITS(4)) m3 ();

  memory_march_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .seed(seed), .mem(m1.master),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_err_valid(fev), .first_err_addr(fea)
  );

  memory_march_sequencer #(.ERR_BITS(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .seed(seed), .mem(m3.master),
    .busy(busy3), .done(done3), .pass(pass3), .err_count(err3),
    .first_err_valid(fev3), .first_err_addr(fea3)
  );

  assign m3.mem_rdata = 4'h0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] stored(input logic [3:0] a, input logic [3:0] v);
    return (a == fault_addr) ? ((v | fault_or) & ~fault_and) : v;
  endfunction

  initial for (int i = 0; i < 16; i++) mem[i] = 4'h0;

  // Single-port memory with one cycle of read latency and an optional faulty cell.
  always @(posedge clk) begin
    if (m1.mem_we) mem[m1.mem_addr] <= m1.mem_wdata;
    m1.mem_rdata <= stored(m1.mem_addr, mem[m1.mem_addr]);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reads in time order: ascending reads of pat, then descending reads of ~pat.
  function automatic void ref_run(input logic [3:0] s, input bit tie0, output int cnt, output int first);
    logic [3:0] a, e, rd;
    cnt = 0;
    first = -1;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 16; i++) begin
        a  = (p == 0) ? 4'(i) : 4'(15 - i);
        e  = (p == 0) ? (s ^ a) : ~(s ^ a);
        rd = tie0 ? 4'h0 : stored(a, e);
        if (rd != e) begin
          cnt++;
          if (first < 0) first = int'(a);
        end
      end
    end
  endfunction

  task automatic port_chk(input int k, input logic [3:0] s);
    int ph, i;
    logic [3:0] a, wd;
    logic we;
    ph = (k - 1) / 16;
    i  = (k - 1) % 16;
    a  = (ph < 2) ? 4'(i) : 4'(15 - i);
    we = (ph == 0) || (ph == 2);
    wd = (ph == 0) ? (s ^ a) : (ph == 2) ? ~(s ^ a) : 4'h0;
    chk($sformatf("port_k%0d", k), {23'd0, m1.mem_we, m1.mem_addr, m1.mem_wdata}, {23'd0, we, a, wd});
  endtask

  task automatic full_run(input logic [3:0] s, input bit pulse_ign);
    int cnt, first, cnt3, first3;
    seed  = s;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("acc_busy", busy, 1);
    chk("acc_done", done, 0);
    chk("acc_err", err_count, 0);
    chk("acc_fev", fev, 0);
    for (int k = 1; k <= 64; k++) begin
      port_chk(k, s);
      if (pulse_ign && (k == 10 || k == 40)) begin
        start = 1'b1;
        seed  = 4'($urandom);
      end
      tick();
      start = 1'b0;
    end
    chk("drain_port", {m1.mem_we, m1.mem_addr}, 0);
    chk("drain_done", done, 0);
    chk("drain_busy", busy, 1);
    tick();
    ref_run(s, 1'b0, cnt, first);
    ref_run(s, 1'b1, cnt3, first3);
    chk("end_done", done, 1);
    chk("end_busy", busy, 0);
    chk("end_pass", pass, (cnt == 0));
    chk("end_err", err_count, (cnt > 255) ? 255 : cnt);
    chk("end_fev", fev, (cnt > 0));
    chk("end_fea", fea, (first < 0) ? 0 : first);
    chk("sat_err", err3, (cnt3 > 7) ? 7 : cnt3);
    chk("sat_fea", fea3, (first3 < 0) ? 0 : first3);
    chk("sat_pass", pass3, (cnt3 == 0));
  endtask

  task automatic all_zero(input string tag);
    chk({tag, "_m1"}, {m1.mem_we, m1.mem_addr, m1.mem_wdata}, 0);
    chk({tag, "_st"}, {busy, done, pass, fev, fea, err_count}, 0);
    chk({tag, "_d3"}, {m3.mem_we, m3.mem_addr, m3.mem_wdata, busy3, done3, pass3, fev3, fea3, err3}, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    seed  = 4'h0;
    #2;
    all_zero("reset");
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    full_run(4'hA, 1'b0);

    fault_addr = 4'h5;
    fault_or   = 4'h1;
    full_run(4'hA, 1'b0);
    chk("stuck_err", err_count, 1);
    chk("stuck_fea", fea, 5);

    fault_or = 4'h0;
    full_run(4'($urandom), 1'b0);

    seed  = 4'($urandom);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k < 20; k++) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_pass", pass, 0);
    chk("abort_port", {m1.mem_we, m1.mem_addr}, 0);
    chk("abort_err", err_count, 0);
    tick();
    chk("abort_idle", busy, 0);
    full_run(4'($urandom), 1'b0);

    fault_addr = 4'($urandom);
    fault_or   = 4'($urandom);
    fault_and  = 4'($urandom);
    full_run(4'($urandom), 1'b1);

    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("blk_busy", busy, 0);
    chk("blk_done", done, 1);

    for (int r = 0; r < 3; r++) begin
      fault_addr = 4'($urandom);
      fault_or   = 4'($urandom);
      fault_and  = 4'($urandom);
      full_run(4'($urandom), 1'b0);
    end

    fault_or  = 4'h0;
    fault_and = 4'h0;
    seed  = 4'($urandom);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k < 20; k++) tick();
    #2;
    rst_n = 1'b0;
    #1;
    all_zero("async");
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk("post_rst_idle", {busy, m1.mem_we, done}, 0);
      tick();
    end
    full_run(4'($urandom), 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/memory_march_sequencer.md
Name: memory_march_sequencer

Overview:
- Self-test controller that owns the on-chip memory macro's port (we, addr, wdata, rdata).
- On a start pulse it runs a four-phase march test over every address and compares read data against a seed-derived pattern.
- It reports pass/fail, a saturating error count and the first failing address.
- Sits between the tile's IO pins and the memory instance; while the sequencer is idle, the memory port is quiescent.

Parameters:
- ADDR_BITS, 4, memory address width; N = 2^ADDR_BITS words.
- DATA_BITS, 4, memory word width.
- READ_LATENCY, 1, cycles from mem_addr to valid mem_rdata; legal range 0..4.
- ERR_BITS, 8, width of err_count.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset: one clock; reset is asynchronous and active-low.
- start  in  1  start request; one-cycle pulse or level.
- abort  in  1  synchronous abort.
- seed  in  DATA_BITS  pattern seed, sampled on an accepted start.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_BITS  memory address.
- mem_wdata  out  DATA_BITS  memory write data.
- mem_rdata  in  DATA_BITS  memory read data.
- busy  out  1  test in progress.
- done  out  1  test complete; held until the next start.
- pass  out  1  valid while done; 1 when err_count == 0.
- err_count  out  ERR_BITS  mismatch count, saturating.
- first_err_valid  out  1  at least one mismatch seen.
- first_err_addr  out  ADDR_BITS  address of the first mismatch.

Behaviour:
- Reset (async, rst_n=0):
  - State = IDLE.
  - All outputs 0: mem_we, mem_addr, mem_wdata, busy, done, pass, err_count, first_err_*.
  - Compare pipeline valid bits cleared.
- Pattern: pat(a) = seed_q XOR a, with a zero-extended or truncated to DATA_BITS.
- States:
  - IDLE, DONE: mem_we=0, mem_addr=0, mem_wdata=0.
  - W_UP: a = 0..N-1; mem_we=1; mem_wdata = pat(a).
  - R_UP: a = 0..N-1; mem_we=0; expect pat(a).
  - W_DN: a = N-1..0; mem_we=1; mem_wdata = ~pat(a).
  - R_DN: a = N-1..0; mem_we=0; expect ~pat(a).
  - DRAIN: READ_LATENCY cycles (skipped if 0); mem_we=0, mem_addr=0.
  - Each of W_UP/R_UP/W_DN/R_DN lasts exactly N cycles.
- Memory port outputs are a function of the registered state and address counter only; nothing is combinational from inputs.
- Start:
  - Accepted on a rising edge where start=1 and state is IDLE or DONE.
  - On acceptance: seed_q <= seed; err_count, first_err_*, done and pass cleared; state <= W_UP; busy <= 1.
  - start while busy is ignored.
- Compare pipeline:
  - Each R_* cycle pushes {valid, addr, expected} into a READ_LATENCY-deep delay line.
  - At the output stage, valid and mem_rdata != expected counts as a mismatch.
  - With READ_LATENCY=0 the compare happens in the same cycle.
- On mismatch:
  - err_count increments, saturating at 2^ERR_BITS-1.
  - If first_err_valid=0: first_err_addr <= addr and first_err_valid <= 1.
  - first_err_addr keeps counting-invariant capture after saturation.
- Completion:
  - On the edge leaving DRAIN (or R_DN if READ_LATENCY=0): busy <= 0, done <= 1, pass <= (final err_count == 0).
  - This edge includes the last compare.
  - done rises exactly 4N+READ_LATENCY cycles after the start-accept edge.
- Abort:
  - abort=1 at any edge while busy: state <= IDLE, busy=0, done=0, pass=0.
  - Pipeline valid bits cleared; err_count and first_err_* retain their values.
  - abort has priority over start and over completion in the same cycle.
  - abort in IDLE/DONE has no effect, except that it blocks a simultaneous start.
- Reset mid-test: immediate return to the reset values; no partial result survives.

Test Plan (ADDR_BITS=4, DATA_BITS=4, READ_LATENCY=1, ERR_BITS=8, seed=4'hA, ideal memory model unless stated):
- Clean run:
  - Stimulus: start pulse.
  - Response: mem_we=1 for cycles 1-16 with wdata A,B,8,9,...; done rises 65 cycles after accept; pass=1; err_count=0; first_err_valid=0.
- Stuck-at-1, bit0, address 5:
  - R_UP reads F (expected F), no error.
  - R_DN reads 1 (expected 0).
  - Response: err_count=1, first_err_addr=5, pass=0.
- Memory rdata tied to 0, with ERR_BITS=3:
  - 30 true mismatches (pat zero at a=A; ~pat zero at a=5).
  - Response: err_count saturates at 7, first_err_addr=0, pass=0.
- Abort:
  - Stimulus: abort at cycle 20 after accept.
  - Response: busy=0 next edge, done=0, mem_we=0, mem_addr=0.
  - A following start runs clean to done in 65 cycles with err_count=0.
- Restart and ignored start:
  - Start pulses at cycles 10 and 40 during a run are ignored; done still at 65.
  - A second start from DONE after a faulty run clears err_count/first_err_valid on accept.
- Async reset:
  - Stimulus: rst_n low mid-R_UP, between clock edges.
  - Response: all outputs 0 immediately, without waiting for a clock edge.
  - After release, no activity until start.
